pc_sequencer: RTL and testbench

Parametrised program-counter sequencer, the next generation of the processor's fetch-address register. Beyond sequential increment and an external reload, it supports PC-relative branches, absolute jumps, and call/return through an internal return-address stack (RAS) of configurable depth. It sits at the head of the fetch stage and drives the instruction-memory address every cycle.

---
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Signal bundle between the fetch-control logic (master) and the PC sequencer (slave).
// en qualifies a request; there is no backpressure, so the sequencer accepts every cycle.
interface pc_sequencer_if #(
    parameter int NO_BITS   = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic               init_load;
    logic [NO_BITS-1:0] init_pc;
    logic               en;
    logic [1:0]         mode;
    logic [NO_BITS-1:0] offset;
    logic [NO_BITS-1:0] target;
    logic [NO_BITS-1:0] address;
    logic [CW-1:0]      ras_count;
    logic               ras_empty;
    logic               ras_full;
    logic               ras_ovf;
    logic               ras_unf;

    modport master (
        output init_load, init_pc, en, mode, offset, target,
        input  address, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  init_load, init_pc, en, mode, offset, target,
        output address, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-address register with sequential step, relative branch, absolute call and
// return through a circular return-address stack that keeps the newest RAS_DEPTH entries.
module pc_sequencer #(
    parameter int                 NO_BITS   = 32,
    parameter int                 STEP      = 4,
    parameter int                 RAS_DEPTH = 4,
    parameter logic [NO_BITS-1:0] RESET_PC  = '0
) (
    input  logic         clk,
    input  logic         rst,
    pc_sequencer_if.slave bus
);
    localparam int                 PW     = $clog2(RAS_DEPTH);
    localparam int                 CW     = PW + 1;
    localparam logic [NO_BITS-1:0] STEP_W = NO_BITS'(STEP);
    localparam logic [CW-1:0]      FULL_C = CW'(RAS_DEPTH);

    typedef enum logic [1:0] {
        MODE_SEQ    = 2'b00,
        MODE_BRANCH = 2'b01,
        MODE_CALL   = 2'b10,
        MODE_RET    = 2'b11
    } mode_e;

    logic [NO_BITS-1:0] addr_q, addr_d;
    logic [PW-1:0]      top_q, top_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [NO_BITS-1:0] ras_q [RAS_DEPTH];

    logic               push_en;
    logic [PW-1:0]      push_idx;
    logic [NO_BITS-1:0] push_data;
    logic [NO_BITS-1:0] seq_addr;

    assign seq_addr = addr_q + STEP_W;

    always_comb begin
        addr_d    = addr_q;
        top_d     = top_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        push_en   = 1'b0;
        push_idx  = top_q + PW'(1);
        push_data = seq_addr;

        if (bus.init_load) begin
            addr_d  = bus.init_pc;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (bus.en) begin
            case (mode_e'(bus.mode))
                MODE_SEQ:    addr_d = seq_addr;
                MODE_BRANCH: addr_d = addr_q + bus.offset;
                MODE_CALL: begin
                    // When full, top+1 is the oldest slot, so the push overwrites it.
                    push_en = 1'b1;
                    top_d   = top_q + PW'(1);
                    addr_d  = bus.target;
                    if (count_q == FULL_C) ovf_d = 1'b1;
                    else                   count_d = count_q + CW'(1);
                end
                MODE_RET: begin
                    if (count_q == '0) begin
                        addr_d = seq_addr;
                        unf_d  = 1'b1;
                    end else begin
                        addr_d  = ras_q[top_q];
                        top_d   = top_q - PW'(1);
                        count_d = count_q - CW'(1);
                    end
                end
                default: addr_d = seq_addr;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= RESET_PC;
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage needs no reset: ras_count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push_en) ras_q[push_idx] <= push_data;
    end

    assign bus.address   = addr_q;
    assign bus.ras_count = count_q;
    assign bus.ras_empty = (count_q == '0);
    assign bus.ras_full  = (count_q == FULL_C);
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, directed corner sequences and
// randomized traffic against a queue-based return-stack model.
module tb_pc_sequencer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.NO_BITS(32), .RAS_DEPTH(DEPTH)) bus ();

  pc_sequencer #(.NO_BITS(32), .STEP(4), .RAS_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_unf;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        il;
    logic [31:0] ipc;
    logic        en;
    logic [1:0]  mode;
    logic [31:0] off;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    int          e_cnt;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc = 32'h0;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void model_step(input logic il, input logic [31:0] ipc, input logic en,
                                     input logic [1:0] mode, input logic [31:0] off,
                                     input logic [31:0] tgt);
    if (il) begin
      m_pc = ipc;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (en) begin
      case (mode)
        2'b00: m_pc = m_pc + 32'd4;
        2'b01: m_pc = m_pc + off;
        2'b10: begin
          if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_ras.push_back(m_pc + 32'd4);
          m_pc = tgt;
        end
        default: begin
          if (m_ras.size() == 0) begin
            m_pc = m_pc + 32'd4;
            m_unf = 1'b1;
          end else begin
            m_pc = m_ras.pop_back();
          end
        end
      endcase
    end
  endfunction

  task automatic drive(input logic il, input logic [31:0] ipc, input logic en,
                       input logic [1:0] mode, input logic [31:0] off, input logic [31:0] tgt);
    bus.init_load = il;
    bus.init_pc   = ipc;
    bus.en        = en;
    bus.mode      = mode;
    bus.offset    = off;
    bus.target    = tgt;
    model_step(il, ipc, en, mode, off, tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] e;
    exp_q.push_back(m_pc);
    e = exp_q.pop_front();
    chk({tag, ".address"}, bus.address, e);
    chk({tag, ".ras_count"}, 32'(bus.ras_count), 32'(m_ras.size()));
    chk({tag, ".ras_empty"}, 32'(bus.ras_empty), 32'(m_ras.size() == 0));
    chk({tag, ".ras_full"}, 32'(bus.ras_full), 32'(m_ras.size() == DEPTH));
    chk({tag, ".ras_ovf"}, 32'(bus.ras_ovf), 32'(m_ovf));
    chk({tag, ".ras_unf"}, 32'(bus.ras_unf), 32'(m_unf));
  endtask

  task automatic call(input logic [31:0] tgt);
    drive(1'b0, 32'h0, 1'b1, 2'b10, 32'h0, tgt);
  endtask

  task automatic ret();
    drive(1'b0, 32'h0, 1'b1, 2'b11, 32'h0, 32'h0);
  endtask

  task automatic seq();
    drive(1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 32'h0);
  endtask

  initial begin
    bus.init_load = 1'b0;
    bus.init_pc   = '0;
    bus.en        = 1'b0;
    bus.mode      = 2'b00;
    bus.offset    = '0;
    bus.target    = '0;
    model_reset();

    tbl[0]  = '{1'b1, 32'h100,      1'b0, 2'b00, 32'h0,        32'h0,   32'h100,      0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 2'b01, 32'hFFFFFFF0, 32'h0,   32'hF0,       0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 2'b00, 32'h0,        32'h0,   32'hF4,       0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 2'b10, 32'h0,        32'h200, 32'h200,      1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 2'b00, 32'h0,        32'h0,   32'h204,      1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 2'b11, 32'h0,        32'h0,   32'hF8,       0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 32'h0,        1'b1, 2'b11, 32'h0,        32'h0,   32'hFC,       0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 32'h0,        1'b0, 2'b10, 32'h40,       32'h300, 32'hFC,       0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 32'hFFFFFFFC, 1'b1, 2'b10, 32'h0,        32'h500, 32'hFFFFFFFC, 0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 2'b00, 32'h0,        32'h0,   32'h0,        0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 2'b01, 32'h8,        32'h0,   32'h8,        0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 32'h0,        1'b1, 2'b10, 32'h0,        32'h40,  32'h40,       1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 2'b11, 32'h0,        32'h0,   32'hC,        0, 1'b0, 1'b0};

    // reset state, held before any release
    #12;
    chk("reset.address", bus.address, 32'h0);
    chk("reset.ras_count", 32'(bus.ras_count), 32'h0);
    chk("reset.ras_empty", 32'(bus.ras_empty), 32'h1);
    chk("reset.ras_full", 32'(bus.ras_full), 32'h0);
    chk("reset.flags", {30'h0, bus.ras_ovf, bus.ras_unf}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // sequential from reset: 4, 8, 12
    for (int i = 1; i <= 3; i++) begin
      seq();
      chk("seq.address", bus.address, 32'(4 * i));
      chk("seq.ras_empty", 32'(bus.ras_empty), 32'h1);
    end

    // vector table
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e_addr);
      drive(tbl[i].il, tbl[i].ipc, tbl[i].en, tbl[i].mode, tbl[i].off, tbl[i].tgt);
      chk($sformatf("tbl%0d.address", i), bus.address, exp_q.pop_front());
      chk($sformatf("tbl%0d.ras_count", i), 32'(bus.ras_count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d.flags", i), {30'h0, bus.ras_ovf, bus.ras_unf},
          {30'h0, tbl[i].e_ovf, tbl[i].e_unf});
    end

    // five nested calls overflow a four-deep stack, five returns underflow it
    drive(1'b1, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
    call(32'h10); call(32'h20); call(32'h30); call(32'h40); call(32'h50);
    chk("nest.address", bus.address, 32'h50);
    chk("nest.ras_full", 32'(bus.ras_full), 32'h1);
    chk("nest.ras_ovf", 32'(bus.ras_ovf), 32'h1);
    chk("nest.ras_count", 32'(bus.ras_count), 32'(DEPTH));
    ret(); chk("nest.ret1", bus.address, 32'h44);
    ret(); chk("nest.ret2", bus.address, 32'h34);
    ret(); chk("nest.ret3", bus.address, 32'h24);
    ret(); chk("nest.ret4", bus.address, 32'h14);
    chk("nest.unf_before", 32'(bus.ras_unf), 32'h0);
    ret(); chk("nest.ret5", bus.address, 32'h18);
    chk("nest.unf_after", 32'(bus.ras_unf), 32'h1);
    chk("nest.ovf_sticky", 32'(bus.ras_ovf), 32'h1);

    // back-to-back call then return
    call(32'h700); ret();
    chk("b2b.address", bus.address, 32'h1C);
    check_model("b2b");

    // asynchronous reset between edges after two calls
    call(32'h800); call(32'h900);
    check_model("prerst");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst.address", bus.address, 32'h0);
    chk("arst.ras_count", 32'(bus.ras_count), 32'h0);
    chk("arst.ras_empty", 32'(bus.ras_empty), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 2'(i + 1), 32'h40, 32'hA00);
      chk("hold.address", bus.address, 32'h0);
    end
    check_model("hold");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic        il, en;
      logic [1:0]  mode;
      logic [31:0] off, tgt, ipc;
      il   = ($urandom_range(0, 39) == 0);
      en   = ($urandom_range(0, 7) != 0);
      mode = 2'($urandom_range(0, 3));
      off  = 32'($signed($urandom_range(0, 128)) * 4 - 256);
      tgt  = $urandom & 32'hFFFF_FFFC;
      ipc  = $urandom & 32'hFFFF_FFFC;
      drive(il, ipc, en, mode, off, tgt);
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
